mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sole owner of the single-port 512x16 RAM; shares it between the CPU and an external loader port (ext_*).
//  Sequences boot: CPU held in reset while loader writes the program, then CPU released.
//  In run mode the CPU has absolute priority; the loader only uses cycles where the CPU issues no read or write.
// PARAMETERS
//  DATA_W       16  RAM / bus data width
//  ADDR_W       9   RAM address width
//  RELEASE_CYC  2   cycles cpu_reset stays high in RELEASE after boot_done (>=1)
//  WAIT_W       8   width of saturating ext wait counter
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       synchronous, active-high
//  boot_mode       in   1       sampled only while reset=1: 1 -> BOOT, 0 -> RELEASE
//  boot_done       in   1       1-cycle pulse from loader: leave BOOT
//  cpu_mem_cmd     in   2       CPU command: 1=MREAD, 3=MWRITE, any other value idle
//  cpu_mem_addr    in   ADDR_W  CPU address
//  cpu_write_data  in   DATA_W  CPU write data
//  cpu_read_data   out  DATA_W  = ram_dout (pass-through)
//  cpu_reset       out  1       reset to the CPU
//  ext_req         in   1       loader request; held with ext_we/addr/wdata stable until ext_gnt
//  ext_we          in   1       1=write, 0=read
//  ext_addr        in   ADDR_W  loader address
//  ext_wdata       in   DATA_W  loader write data
//  ext_gnt         out  1       comb.; access performed this cycle
//  ext_rvalid      out  1       registered; ext_rdata valid this cycle
//  ext_rdata       out  DATA_W  = ram_dout
//  ext_wait_cnt    out  WAIT_W  saturating count of cycles with ext_req=1 & ext_gnt=0
//  ram_addr        out  ADDR_W  comb. mux to RAM
//  ram_din         out  DATA_W  comb. mux to RAM
//  ram_write       out  1       comb. RAM write enable
//  ram_dout        in   DATA_W  RAM read data, 1-cycle synchronous latency
// BEHAVIOUR
//  States: BOOT, RELEASE, RUN (2-bit reg); rel_cnt counter.
//  reset=1: state<=boot_mode?BOOT:RELEASE; rel_cnt<=0; ext_rvalid<=0; ext_wait_cnt<=0.
//   Aborts any in-flight read (no rvalid after reset).
//  cpu_reset = 1 in BOOT and RELEASE, 0 in RUN (comb. from state).
//  BOOT: ext_gnt=ext_req; CPU command ignored (cpu_reset high). boot_done -> RELEASE, rel_cnt<=0.
//   boot_done with ext_req in the same cycle: access still granted, then transition.
//  RELEASE: ext_gnt=0, ram_write=0; rel_cnt++; rel_cnt==RELEASE_CYC-1 -> RUN.
//  RUN: boot_mode, boot_done ignored; stays in RUN until reset.
//   cpu_busy = (cmd==1 | cmd==3). cpu_busy: RAM driven by CPU, ram_write=(cmd==3), ext_gnt=0.
//   !cpu_busy: ext_gnt=ext_req; RAM driven by ext port when granted.
//  Mux: granted ext -> ram_addr=ext_addr, ram_din=ext_wdata, ram_write=ext_we;
//   else CPU fields, ram_write=(state==RUN & cmd==3). Nothing granted -> ram_write=0, addr=cpu_mem_addr.
//  ext_rvalid <= ext_gnt & ~ext_we (1 cycle after granted read); ext_rdata read in that cycle.
//   Back-to-back granted reads -> rvalid every cycle; CPU read issued the cycle after does not disturb it.
//  ext_wait_cnt: +1 per stalled cycle, saturates at 2^WAIT_W-1, never wraps; cleared only by reset.
//  Address is full ADDR_W; no wrap or range check. No write merging; one access per cycle.
// TESTING
//  1 reset w/ boot_mode=1; ext writes 0xA5A5 @0x000..0x003 -> ram_write=1 each cycle, cpu_reset=1.
//  2 BOOT ext read @0x002 -> ext_rvalid=1 next cycle, ext_rdata=0xA5A5.
//  3 boot_done pulse, RELEASE_CYC=2 -> cpu_reset high 2 more cycles, then 0; ext_req blocked in RELEASE.
//  4 RUN: cpu_mem_cmd=1 and ext_req=1 same cycle -> ext_gnt=0, ram_addr=cpu addr, ext_wait_cnt=1;
//   next cycle cmd=0 -> ext_gnt=1.
//  5 RUN: CPU MWRITE 0x1234 @0x10A -> ram_write=1, ram_din=0x1234; ext_req held 300 cycles busy -> wait_cnt=255.
//  6 reset asserted the cycle after a granted ext read -> ext_rvalid=0, state per boot_mode, wait_cnt=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter sequencing loader boot and CPU/loader sharing
module mem_arbiter #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 9,
  parameter int RELEASE_CYC = 2,
  parameter int WAIT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_mode,
  input  logic              boot_done,
  input  logic [1:0]        cpu_mem_cmd,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              cpu_reset,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [WAIT_W-1:0] ext_wait_cnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int REL_W = (RELEASE_CYC > 2) ? $clog2(RELEASE_CYC) : 1;

  localparam logic [1:0] CMD_MREAD  = 2'd1;
  localparam logic [1:0] CMD_MWRITE = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [REL_W-1:0] rel_cnt;
  logic [REL_W-1:0] rel_cnt_nxt;
  logic             cpu_busy;
  logic             cpu_wr;

  // The CPU only counts as a RAM user when it issues a real read or write.
  assign cpu_busy = (cpu_mem_cmd == CMD_MREAD) || (cpu_mem_cmd == CMD_MWRITE);
  assign cpu_wr   = (cpu_mem_cmd == CMD_MWRITE);

  // Both consumers see the RAM output directly; ext_rvalid qualifies the loader copy.
  assign cpu_read_data = ram_dout;
  assign ext_rdata     = ram_dout;

  // State and release-counter registers; boot_mode picks the post-reset state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= boot_mode ? ST_BOOT : ST_RELEASE;
      rel_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rel_cnt <= rel_cnt_nxt;
    end
  end

  // Next-state logic, CPU reset, loader grant and RAM port mux.
  always_comb begin
    state_nxt   = state;
    rel_cnt_nxt = rel_cnt;
    cpu_reset   = 1'b1;
    ext_gnt     = 1'b0;
    ram_addr    = cpu_mem_addr;
    ram_din     = cpu_write_data;
    ram_write   = 1'b0;

    unique case (state)
      ST_BOOT: begin
        // Loader owns the RAM; a request coinciding with boot_done is still served.
        ext_gnt = ext_req;
        if (boot_done) begin
          state_nxt   = ST_RELEASE;
          rel_cnt_nxt = '0;
        end
      end
      ST_RELEASE: begin
        // RAM is quiet while the CPU is being brought out of reset.
        rel_cnt_nxt = rel_cnt + REL_W'(1);
        if (rel_cnt == REL_W'(RELEASE_CYC - 1)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // CPU has absolute priority; loader fills idle CPU cycles only.
        cpu_reset = 1'b0;
        ext_gnt   = ext_req && !cpu_busy;
        ram_write = cpu_wr;
      end
      default: begin
        // Unreachable encoding: recover through the release sequence.
        state_nxt   = ST_RELEASE;
        rel_cnt_nxt = '0;
      end
    endcase

    if (ext_gnt) begin
      ram_addr  = ext_addr;
      ram_din   = ext_wdata;
      ram_write = ext_we;
    end
  end

  // Read-data valid follows a granted loader read by one cycle, matching RAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_rvalid <= 1'b0;
    end else begin
      ext_rvalid <= ext_gnt && !ext_we;
    end
  end

  // Saturating count of loader stall cycles, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_wait_cnt <= '0;
    end else if (ext_req && !ext_gnt && (ext_wait_cnt != {WAIT_W{1'b1}})) begin
      ext_wait_cnt <= ext_wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a behavioural RAM
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        boot_mode;
  logic        boot_done;
  logic [1:0]  cpu_mem_cmd;
  logic [8:0]  cpu_mem_addr;
  logic [15:0] cpu_write_data;
  logic [15:0] cpu_read_data;
  logic        cpu_reset;
  logic        ext_req;
  logic        ext_we;
  logic [8:0]  ext_addr;
  logic [15:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [15:0] ext_rdata;
  logic [7:0]  ext_wait_cnt;
  logic [8:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_write;
  logic [15:0] ram_dout;

  logic [15:0] mem [0:511];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset), .boot_mode(boot_mode), .boot_done(boot_done),
    .cpu_mem_cmd(cpu_mem_cmd), .cpu_mem_addr(cpu_mem_addr),
    .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
    .cpu_reset(cpu_reset), .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_gnt(ext_gnt),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ext_wait_cnt(ext_wait_cnt),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_write(ram_write),
    .ram_dout(ram_dout)
  );

  // Synchronous single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic        boot_done;
    logic [1:0]  cmd;
    logic [8:0]  caddr;
    logic [15:0] cdata;
    logic        req;
    logic        we;
    logic [8:0]  eaddr;
    logic [15:0] edata;
    logic        x_cpu_reset;
    logic        x_gnt;
    logic        x_write;
    logic [8:0]  x_addr;
    logic [15:0] x_din;
    logic        x_rvalid;
    logic        x_chk_rdata;
    logic [15:0] x_rdata;
    logic [7:0]  x_wait;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic bd, input logic [1:0] cmd, input logic [8:0] ca,
                              input logic [15:0] cd, input logic rq, input logic we,
                              input logic [8:0] ea, input logic [15:0] ed,
                              input logic xr, input logic xg, input logic xw,
                              input logic [8:0] xa, input logic [15:0] xd,
                              input logic xv, input logic xcr, input logic [15:0] xrd,
                              input logic [7:0] xwt);
    vec_t v;
    v.boot_done = bd; v.cmd = cmd; v.caddr = ca; v.cdata = cd;
    v.req = rq; v.we = we; v.eaddr = ea; v.edata = ed;
    v.x_cpu_reset = xr; v.x_gnt = xg; v.x_write = xw; v.x_addr = xa; v.x_din = xd;
    v.x_rvalid = xv; v.x_chk_rdata = xcr; v.x_rdata = xrd; v.x_wait = xwt;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    reset = 1'b1; boot_mode = 1'b1; boot_done = 1'b0;
    cpu_mem_cmd = 2'd0; cpu_mem_addr = '0; cpu_write_data = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;

    //           bd cmd ca      cd       rq we ea      ed        cpr gnt wr addr    din      rv crd rdata    wait
    // BOOT: loader writes 0xA5A5 to 0..3, then reads 2
    vecs.push_back(mk(0, 0, 9'h000, 16'h0000, 1, 1, 9'h000, 16'hA5A5, 1, 1, 1, 9'h000, 16'hA5A5, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 0, 9'h000, 16'h0000, 1, 1, 9'h001, 16'hA5A5, 1, 1, 1, 9'h001, 16'hA5A5, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 0, 9'h000, 16'h0000, 1, 1, 9'h002, 16'hA5A5, 1, 1, 1, 9'h002, 16'hA5A5, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 0, 9'h000, 16'h0000, 1, 1, 9'h003, 16'hA5A5, 1, 1, 1, 9'h003, 16'hA5A5, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 0, 9'h000, 16'h0000, 1, 0, 9'h002, 16'h0000, 1, 1, 0, 9'h002, 16'h0000, 0, 0, 16'h0, 0));
    // read data returns; CPU MWRITE is ignored while BOOT holds it in reset
    vecs.push_back(mk(0, 3, 9'h055, 16'hDEAD, 0, 0, 9'h000, 16'h0000, 1, 0, 0, 9'h055, 16'hDEAD, 1, 1, 16'hA5A5, 0));
    // boot_done with a loader write in the same cycle: still granted
    vecs.push_back(mk(1, 0, 9'h000, 16'h0000, 1, 1, 9'h004, 16'h0BEE, 1, 1, 1, 9'h004, 16'h0BEE, 0, 0, 16'h0, 0));
    // RELEASE: loader blocked (stalls), CPU write has no effect
    vecs.push_back(mk(0, 0, 9'h000, 16'h0000, 1, 0, 9'h000, 16'h0000, 1, 0, 0, 9'h000, 16'h0000, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 3, 9'h010, 16'h7777, 0, 0, 9'h000, 16'h0000, 1, 0, 0, 9'h010, 16'h7777, 0, 0, 16'h0, 1));
    // RUN: CPU read wins over loader write, loader takes the next idle cycle
    vecs.push_back(mk(0, 1, 9'h0AA, 16'h0000, 1, 1, 9'h005, 16'hBEEF, 0, 0, 0, 9'h0AA, 16'h0000, 0, 0, 16'h0, 1));
    vecs.push_back(mk(0, 0, 9'h0AA, 16'h0000, 1, 1, 9'h005, 16'hBEEF, 0, 1, 1, 9'h005, 16'hBEEF, 0, 0, 16'h0, 2));
    // CPU MWRITE 0x1234 @0x10A
    vecs.push_back(mk(0, 3, 9'h10A, 16'h1234, 0, 0, 9'h000, 16'h0000, 0, 0, 1, 9'h10A, 16'h1234, 0, 0, 16'h0, 2));
    // back-to-back loader reads, then a CPU read that must not disturb rvalid
    vecs.push_back(mk(0, 0, 9'h000, 16'h0000, 1, 0, 9'h10A, 16'h0000, 0, 1, 0, 9'h10A, 16'h0000, 0, 0, 16'h0, 2));
    vecs.push_back(mk(0, 0, 9'h000, 16'h0000, 1, 0, 9'h000, 16'h0000, 0, 1, 0, 9'h000, 16'h0000, 1, 1, 16'h1234, 2));
    vecs.push_back(mk(0, 1, 9'h003, 16'h0000, 0, 0, 9'h000, 16'h0000, 0, 0, 0, 9'h003, 16'h0000, 1, 1, 16'hA5A5, 2));
    // boot_done ignored in RUN; CPU read of 3 returns on the shared bus
    vecs.push_back(mk(1, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 0, 0, 0, 9'h000, 16'h0000, 0, 1, 16'hA5A5, 2));
    // cmd=2 is idle: loader granted at top address
    vecs.push_back(mk(0, 2, 9'h000, 16'h0000, 1, 1, 9'h1FF, 16'hFFFF, 0, 1, 1, 9'h1FF, 16'hFFFF, 0, 0, 16'h0, 2));

    // Reset state with boot_mode=1
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("reset_rvalid", {31'd0, ext_rvalid}, 32'd0);
    chk("reset_wait", {24'd0, ext_wait_cnt}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      boot_done = vecs[i].boot_done; cpu_mem_cmd = vecs[i].cmd;
      cpu_mem_addr = vecs[i].caddr; cpu_write_data = vecs[i].cdata;
      ext_req = vecs[i].req; ext_we = vecs[i].we;
      ext_addr = vecs[i].eaddr; ext_wdata = vecs[i].edata;
      #1;
      chk($sformatf("v%0d_cpu_reset", i), {31'd0, cpu_reset}, {31'd0, vecs[i].x_cpu_reset});
      chk($sformatf("v%0d_gnt", i), {31'd0, ext_gnt}, {31'd0, vecs[i].x_gnt});
      chk($sformatf("v%0d_ram_write", i), {31'd0, ram_write}, {31'd0, vecs[i].x_write});
      chk($sformatf("v%0d_ram_addr", i), {23'd0, ram_addr}, {23'd0, vecs[i].x_addr});
      if (vecs[i].x_write) chk($sformatf("v%0d_ram_din", i), {16'd0, ram_din}, {16'd0, vecs[i].x_din});
      chk($sformatf("v%0d_rvalid", i), {31'd0, ext_rvalid}, {31'd0, vecs[i].x_rvalid});
      if (vecs[i].x_chk_rdata) begin
        chk($sformatf("v%0d_ext_rdata", i), {16'd0, ext_rdata}, {16'd0, vecs[i].x_rdata});
        chk($sformatf("v%0d_cpu_rdata", i), {16'd0, cpu_read_data}, {16'd0, vecs[i].x_rdata});
      end
      chk($sformatf("v%0d_wait", i), {24'd0, ext_wait_cnt}, {24'd0, vecs[i].x_wait});
    end

    // Saturation: CPU busy with reads while loader holds a request for 300 cycles
    begin
      int gnt_seen;
      gnt_seen = 0;
      @(negedge clk);
      boot_done = 1'b0; cpu_mem_cmd = 2'd1; cpu_mem_addr = 9'h020;
      ext_req = 1'b1; ext_we = 1'b1; ext_addr = 9'h030; ext_wdata = 16'h5555;
      for (int c = 0; c < 300; c++) begin
        #1;
        if (ext_gnt) gnt_seen++;
        @(negedge clk);
      end
      #1;
      chk("sat_gnt_never", gnt_seen, 0);
      chk("sat_wait_255", {24'd0, ext_wait_cnt}, 32'd255);
    end

    // Reset the cycle after a granted read: rvalid suppressed, boot_mode=0 -> RELEASE
    @(negedge clk);
    cpu_mem_cmd = 2'd0; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 9'h003;
    #1;
    chk("rst_seq_gnt", {31'd0, ext_gnt}, 32'd1);
    @(negedge clk);
    reset = 1'b1; boot_mode = 1'b0; ext_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_seq_rvalid", {31'd0, ext_rvalid}, 32'd0);
    chk("rst_seq_wait", {24'd0, ext_wait_cnt}, 32'd0);
    chk("rst_seq_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    reset = 1'b0; boot_mode = 1'b1;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 9'h040; ext_wdata = 16'h0001;
    #1;
    chk("rel_blocks_gnt0", {31'd0, ext_gnt}, 32'd0);
    chk("rel_no_write0", {31'd0, ram_write}, 32'd0);
    @(negedge clk);
    #1;
    chk("rel_cpu_reset1", {31'd0, cpu_reset}, 32'd1);
    chk("rel_blocks_gnt1", {31'd0, ext_gnt}, 32'd0);
    @(negedge clk);
    #1;
    chk("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("run_gnt", {31'd0, ext_gnt}, 32'd1);
    chk("run_wait2", {24'd0, ext_wait_cnt}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
